load_align_unit: RTL and testbench

//   Load-side counterpart of the store path. Accepts one load request (address, funct3, rd)
//   and issues a word-aligned read on the data-memory port. It waits for the read data,

---
 rtl/riscv_pkg.sv | 36 +++
 rtl/load_extract.sv | 48 ++++
 rtl/load_align_unit.sv | 149 ++++++++++++++
 tb/tb_load_align_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared constants for the load path:
//   - load funct3 encodings (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU)
//   - 2-bit FSM state encoding of load_align_unit (S_IDLE, S_REQ, S_WAIT, S_RESP)
//   - load_fault(): flags an illegal funct3 or a misaligned address
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    // 1 when the load cannot be issued to memory: unknown funct3, halfword
    // on an odd address, or word not on a 4-byte boundary.
    function automatic logic load_fault(input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
        logic fault;
        fault = 1'b0;
        case (funct3)
            F3_LB, F3_LBU: fault = 1'b0;
            F3_LH, F3_LHU: fault = addr_lo[0];
            F3_LW:         fault = (addr_lo != 2'b00);
            default:       fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/load_extract.sv
// -----------------------------------------------------------------------------
// load_extract
//   Combinational lane select plus sign/zero extension of a 32-bit
//   little-endian read word.
//   Ports:
//     i_word   in  32  word read from memory
//     i_addr   in   2  byte offset within the word (addr[1:0])
//     i_funct3 in   3  load type (lb/lh/lw/lbu/lhu)
//     o_data   out 32  extended result (0 for an illegal funct3)
// -----------------------------------------------------------------------------
module load_extract
    import riscv_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_addr)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        // Halfword lane only depends on addr[1]; addr[0] is known 0 here
        // because misaligned halfwords never reach memory.
        w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_data = 32'h0000_0000;
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LW:   o_data = i_word;
            F3_LBU:  o_data = {24'h000000, w_byte};
            F3_LHU:  o_data = {16'h0000, w_half};
            default: o_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// -----------------------------------------------------------------------------
// load_align_unit
//   Accepts one load request, issues a word-aligned read to data memory,
//   waits for the read data, aligns and extends the addressed byte/halfword
//   and returns it over a valid/ready handshake. One load outstanding.
//
//   Optional feature macro: LOAD_TIMEOUT_EN
//     defined   -> WAIT gives up after TIMEOUT_CYCLES cycles without
//                  mem_rvalid and returns rsp_err=1, rsp_data=0
//     undefined -> WAIT lasts until mem_rvalid; TIMEOUT_CYCLES unused
//
//   Ports:
//     clk, rst_n              clock (rising edge), async active-low reset
//     req_valid/req_ready     request handshake (ready only in IDLE)
//     req_addr/funct3/rd      byte address, load type, destination tag
//     mem_req/mem_addr        word-aligned read request, held until mem_gnt
//     mem_gnt                 memory accepted the request
//     mem_rvalid/mem_rdata    read data return (honoured only in WAIT)
//     rsp_valid/rsp_ready     response handshake
//     rsp_data/rsp_rd/rsp_err registered result, tag and error flag
// -----------------------------------------------------------------------------
module load_align_unit
    import riscv_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic [2:0]      req_funct3,
    input  logic [4:0]      req_rd,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [4:0]      rsp_rd,
    output logic            rsp_err
);

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_addr;
    logic [2:0]      r_funct3;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_rsp_data;
    logic [4:0]      r_rsp_rd;
    logic            r_rsp_err;
    logic [31:0]     w_extract;

`ifdef LOAD_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES >= 256) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] r_cnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    load_extract u_extract (
        .i_word   (mem_rdata),
        .i_addr   (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .o_data   (w_extract)
    );

    // req_ready must read 0 while reset is held even though the state is IDLE.
    assign req_ready = rst_n && (r_state == S_IDLE);
    assign mem_req   = (r_state == S_REQ);
    assign mem_addr  = mem_req ? {r_addr[XLEN-1:2], 2'b00} : '0;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_rd    = r_rsp_rd;
    assign rsp_err   = r_rsp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_funct3   <= 3'b000;
            r_rd       <= 5'd0;
            r_rsp_data <= '0;
            r_rsp_rd   <= 5'd0;
            r_rsp_err  <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
            r_cnt      <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr   <= req_addr;
                        r_funct3 <= req_funct3;
                        r_rd     <= req_rd;
                        if (load_fault(req_funct3, req_addr[1:0])) begin
                            // Rejected loads skip memory entirely.
                            r_rsp_data <= '0;
                            r_rsp_rd   <= req_rd;
                            r_rsp_err  <= 1'b1;
                            r_state    <= S_RESP;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // Any rvalid coinciding with gnt is ignored: data is only
                    // taken from WAIT onwards.
                    if (mem_gnt) begin
                        r_state <= S_WAIT;
`ifdef LOAD_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        r_rsp_data <= w_extract;
                        r_rsp_rd   <= r_rd;
                        r_rsp_err  <= 1'b0;
                        r_state    <= S_RESP;
                    end
`ifdef LOAD_TIMEOUT_EN
                    else if (r_cnt == CNT_LAST) begin
                        // TIMEOUT_CYCLES WAIT cycles elapsed with no data.
                        r_rsp_data <= '0;
                        r_rsp_rd   <= r_rd;
                        r_rsp_err  <= 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
module tb_load_align_unit;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_err;

    int   checks = 0;
    int   errors = 0;
    rsp_t exp_q[$];

    load_align_unit #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_rd     (req_rd),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_rd     (rsp_rd),
        .rsp_err    (rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pops one expectation per completed handshake.
    task automatic monitor();
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_rd", {27'd0, rsp_rd}, {27'd0, e.rd});
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    $display("RSP rd=%0d data=0x%08h err=%0b", rsp_rd, rsp_data, rsp_err);
                end
            end
        end
    endtask

    // Cycle 0 -> drive request, returns at cycle 1 drive point.
    task automatic start_req(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd,
                             input logic [31:0] ed, input logic ee, input bit push);
        rsp_t e;
        if (push) begin
            e.data = ed; e.rd = rd; e.err = ee;
            exp_q.push_back(e);
        end
        $display("REQ addr=0x%08h f3=%0d rd=%0d exp=0x%08h err=%0b", a, f3, rd, ed, ee);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_addr = a; req_funct3 = f3; req_rd = rd;
        tick();
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_funct3 = 3'b111; req_rd = 5'd31;
    endtask

    // Entered at first REQ cycle; returns at first RESP cycle.
    task automatic serve_mem(input logic [31:0] a, input logic [31:0] word,
                             input bit rv_with_gnt, input int rv_dly);
        chk("mem_req", {31'd0, mem_req}, 32'd1);
        chk("mem_addr", mem_addr, {a[31:2], 2'b00});
        mem_gnt = 1'b1;
        if (rv_with_gnt) begin
            mem_rvalid = 1'b1; mem_rdata = ~word;
        end
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        for (int i = 0; i < rv_dly; i++) begin
            chk("wait_no_rsp", {31'd0, rsp_valid}, 32'd0);
            tick();
        end
        chk("wait_no_rsp", {31'd0, rsp_valid}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = word;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h5A5A_5A5A;
    endtask

    task automatic finish_rsp();
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic load_ok(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] word, input logic [31:0] ed, input bit rvg, input int dly);
        start_req(a, f3, rd, ed, 1'b0, 1'b1);
        serve_mem(a, word, rvg, dly);
        finish_rsp();
    endtask

    task automatic load_bad(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd);
        start_req(a, f3, rd, 32'h0, 1'b1, 1'b1);
        chk("err_no_mem_req", {31'd0, mem_req}, 32'd0);
        finish_rsp();
        chk("err_no_mem_req_after", {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        rsp_t e;
        int   n;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_funct3 = '0; req_rd = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; rsp_ready = 1'b0;
        fork
            monitor();
        join_none

        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        tick();
        chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        // 1. Minimum latency word load (rsp_valid checked at cycle 3).
        load_ok(32'h100, 3'b010, 5'd1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0);
        // 2. Byte loads.
        load_ok(32'h103, 3'b000, 5'd2, 32'h80FF1234, 32'hFFFFFF80, 1'b0, 0);
        load_ok(32'h103, 3'b100, 5'd3, 32'h80FF1234, 32'h00000080, 1'b0, 0);
        load_ok(32'h100, 3'b000, 5'd4, 32'h80FF1234, 32'h00000034, 1'b0, 0);
        load_ok(32'h101, 3'b000, 5'd5, 32'h80FF1234, 32'h00000012, 1'b1, 2);
        load_ok(32'h102, 3'b000, 5'd6, 32'h80FF1234, 32'hFFFFFFFF, 1'b0, 0);
        // 3. Halfword loads and faults.
        load_ok(32'h102, 3'b001, 5'd7, 32'h80010000, 32'hFFFF8001, 1'b0, 0);
        load_ok(32'h102, 3'b101, 5'd8, 32'h80010000, 32'h00008001, 1'b1, 0);
        load_ok(32'h100, 3'b001, 5'd9, 32'h0000F00D, 32'hFFFFF00D, 1'b0, 3);
        load_ok(32'h100, 3'b101, 5'd10, 32'h80FF1234, 32'h00001234, 1'b0, 0);
        load_bad(32'h101, 3'b001, 5'd11);
        load_bad(32'h103, 3'b101, 5'd12);
        load_bad(32'h102, 3'b010, 5'd13);
        load_bad(32'h100, 3'b011, 5'd14);
        load_bad(32'h100, 3'b110, 5'd15);

        // 4. Back-pressure with a queued request.
        start_req(32'h180, 3'b010, 5'd16, 32'hCAFEF00D, 1'b0, 1'b1);
        serve_mem(32'h180, 32'hCAFEF00D, 1'b0, 0);
        e.data = 32'h000000AB; e.rd = 5'd17; e.err = 1'b0;
        exp_q.push_back(e);
        req_valid = 1'b1; req_addr = 32'h185; req_funct3 = 3'b100; req_rd = 5'd17;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_data", rsp_data, 32'hCAFEF00D);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_mem_req", {31'd0, mem_req}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_idle_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        serve_mem(32'h185, 32'h1234AB00, 1'b0, 0);
        finish_rsp();

        // 5. Reset during WAIT aborts the load.
        start_req(32'h300, 3'b010, 5'd18, 32'h0, 1'b0, 1'b0);
        chk("abort_mem_req", {31'd0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_req_ready", {31'd0, req_ready}, 32'd0);
        chk("abort_mem_req0", {31'd0, mem_req}, 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_rsp_data", rsp_data, 32'd0);
        chk("abort_rsp_rd", {27'd0, rsp_rd}, 32'd0);
        chk("abort_rsp_err", {31'd0, rsp_err}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h11112222;
        tick();
        rst_n = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("stray_rvalid_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("stray_rvalid_ready", {31'd0, req_ready}, 32'd1);
        load_ok(32'h200, 3'b010, 5'd19, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 0);

`ifdef LOAD_TIMEOUT_EN
        // 6. Timeout after 16 WAIT cycles.
        start_req(32'h400, 3'b010, 5'd20, 32'h0, 1'b1, 1'b1);
        chk("to_mem_req", {31'd0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk("to_cycles", n, 32'd16);
        mem_rvalid = 1'b1; mem_rdata = 32'h77778888;
        tick();
        mem_rvalid = 1'b0;
        chk("to_late_data", rsp_data, 32'd0);
        chk("to_late_err", {31'd0, rsp_err}, 32'd1);
        finish_rsp();
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("to_late_idle", {31'd0, rsp_valid}, 32'd0);
`else
        n = 0;
`endif

        tick();
        tick();
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
